psr_status_sequencer: RTL and testbench
=======================================

# psr_status_sequencer

Status writer for the processor status register. It owns the 5-bit status word {data_ready, status1, status0, path1, path0} and drives it onto the register's `newstatus` input every cycle. It runs the issue → execute → retire sequence for the two execution paths. It also checks the register's `status` readback against what it wrote one cycle earlier. It sits between the dispatch stage, the two execution paths and the result consumer.

## Interface
Parameters:
- `status_width`, 5: width of the status word. Fixed at 5.
- `TIMEOUT_CYCLES`, 255: maximum number of WAIT cycles before a forced retire. Valid range 2..255.
- `CHECK_EN`, 1: enables the readback mismatch check. When 0, `status_err` is tied to 0.

Ports:
- `clk`, in, 1: clock; all state is updated on the rising edge.
- `preset`, in, 1: reset, asynchronous, active-low.
- `issue_valid`, in, 1: dispatch offers an operation.
- `issue_dual`, in, 1: the offered operation uses both paths. Sampled only with `issue_valid`.
- `issue_ready`, out, 1: high exactly when the state is IDLE.
- `path_start`, out, 2: registered one-cycle start pulse per path.
- `done`, in, 2: per-path completion strobes.
- `retire_ack`, in, 1: the consumer accepts the result.
- `newstatus`, out, 5: status word driven to the register.
- `status`, in, 5: readback from the register.
- `timeout`, out, 1: the last operation was force-retired.
- `status_err`, out, 1: sticky readback mismatch flag.

## Operation
- State encoding, carried in status[3:2]: IDLE=00, ISSUE=01, WAIT=10, RETIRE=11.
- `busy[1:0]` is carried in status[1:0] (path1, path0). `data_ready` is status[4] and is 1 only in RETIRE.
- `newstatus` = {state==RETIRE, state, busy}, driven from registered state.
- IDLE:
  - An issue is accepted when `issue_valid & issue_ready`.
  - On accept: busy ← {issue_dual, 1}, timeout ← 0, next state ISSUE.
- ISSUE: lasts one cycle.
  - `path_start` = busy for this cycle only.
  - busy ← busy & ~done.
  - Next state is always WAIT. The timeout counter is cleared to 0.
- WAIT:
  - busy ← busy & ~done.
  - If (busy & ~done) == 0, go to RETIRE.
  - Otherwise, if count == TIMEOUT_CYCLES−1: busy ← 0, timeout ← 1, go to RETIRE.
  - Otherwise count increments.
- RETIRE:
  - `data_ready` = 1.
  - On `retire_ack`, go to IDLE.
- `done` bits for non-busy paths are ignored. Simultaneous `done[1:0]` clears both bits in one cycle. `done` is ignored in IDLE and RETIRE.
- `retire_ack` outside RETIRE is ignored. `issue_valid` outside IDLE is ignored, with no buffering.
- Readback check:
  - `exp_q` ← newstatus every cycle.
  - `armed` is set at the first rising edge after `preset` deasserts.
  - From the following cycle on, `status != exp_q` sets `status_err`.
  - `status_err` clears only on reset.
- Counter width is 8 bits. It never wraps, because the timeout fires first.

## Timing
- Reset (preset low, asynchronous):
  - state=IDLE, busy=0, count=0, `newstatus`=5'b00000.
  - `issue_ready`=1, `path_start`=0, `timeout`=0, `status_err`=0.
  - `exp_q`=0, armed=0.
- Reset mid-operation aborts immediately. No `path_start` or `data_ready` is emitted afterward.
- Accept at edge E0. ISSUE occupies cycle 1 with the `path_start` pulse. WAIT begins in cycle 2.
- `done` clearing the last busy bit in WAIT cycle k gives RETIRE in cycle k+1. Minimum issue-to-`data_ready` latency is 3 cycles.
- `done` during ISSUE that clears all bits still passes through one WAIT cycle, which then exits to RETIRE.
- `retire_ack` in RETIRE cycle r gives IDLE, with `issue_ready`=1, in cycle r+1. Back-to-back operations are therefore spaced at least 4 cycles apart.
- The register shows `newstatus` one cycle later. The mismatch compare is aligned to that one-cycle latency.
- A timeout triggers after exactly TIMEOUT_CYCLES WAIT cycles with no completion.
- `done` arriving in the same cycle as the timeout threshold takes priority: the operation retires normally with `timeout`=0.

## Test plan
- Reset, then a single-path issue, `done[0]` in the first WAIT cycle, and an ack → `newstatus` sequence 00000, 00101, 01001, 11100, 00000. `path_start`=01 for exactly one cycle.
- Dual issue, `done[1]` at WAIT cycle 1, `done[0]` at WAIT cycle 4 → busy goes 11→01→00. RETIRE starts in the cycle after `done[0]`.
- Dual issue with both `done` bits high in the same WAIT cycle → both cleared at once. RETIRE in the next cycle.
- TIMEOUT_CYCLES=4, single issue, no `done` → RETIRE after 4 WAIT cycles with `timeout`=1 and busy=0. `timeout` clears on the next accept.
- Loop `newstatus` to `status` through a 1-cycle register, then corrupt `status` bit 2 for one cycle → `status_err` rises the next cycle and stays high until `preset` is pulsed low.
- Assert `preset` low during WAIT, asynchronously → `newstatus` is 0 before the next edge. `issue_valid` and `retire_ack` pulses during RETIRE/IDLE misuse are ignored.

Source files
------------

// File: rtl/psr_status_sequencer_if.sv
// Handshake and status-word bundle between the status sequencer and its
// dispatch stage, execution paths, result consumer and status register.
interface psr_status_sequencer_if #(
  parameter int unsigned status_width = 5
);
  logic                    issue_valid;
  logic                    issue_dual;
  logic                    issue_ready;
  logic [1:0]              path_start;
  logic [1:0]              done;
  logic                    retire_ack;
  logic [status_width-1:0] newstatus;
  logic [status_width-1:0] status;
  logic                    timeout;
  logic                    status_err;

  modport master (
    output issue_valid, issue_dual, done, retire_ack, status,
    input  issue_ready, path_start, newstatus, timeout, status_err
  );

  modport slave (
    input  issue_valid, issue_dual, done, retire_ack, status,
    output issue_ready, path_start, newstatus, timeout, status_err
  );
endinterface

// File: rtl/psr_status_sequencer.sv
// Processor status register writer: runs issue/execute/retire for two paths,
// publishes {data_ready, state, busy} and checks the register readback.
module psr_status_sequencer #(
  parameter int unsigned status_width   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CHECK_EN       = 1
) (
  input  logic                  clk,
  input  logic                  preset,
  psr_status_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    WAIT   = 2'b10,
    RETIRE = 2'b11
  } state_t;

  localparam logic [7:0] last_count = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [1:0] busy;
  logic [7:0] count;
  logic [1:0] start_q;
  logic       timeout_q;
  logic [1:0] busy_left;

  assign busy_left = busy & ~bus.done;

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state     <= IDLE;
      busy      <= '0;
      count     <= '0;
      start_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      start_q <= '0;
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            busy      <= {bus.issue_dual, 1'b1};
            start_q   <= {bus.issue_dual, 1'b1};
            timeout_q <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          busy  <= busy_left;
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion is tested before the threshold so a late done wins.
          if (busy_left == '0) begin
            busy  <= '0;
            state <= RETIRE;
          end else if (count == last_count) begin
            busy      <= '0;
            timeout_q <= 1'b1;
            state     <= RETIRE;
          end else begin
            busy  <= busy_left;
            count <= count + 8'd1;
          end
        end
        RETIRE: begin
          if (bus.retire_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready = (state == IDLE);
  assign bus.path_start  = start_q;
  assign bus.timeout     = timeout_q;
  assign bus.newstatus   = {state == RETIRE, state, busy};

  generate
    if (CHECK_EN != 0) begin : g_check
      logic [status_width-1:0] exp_q;
      logic                    armed;
      logic                    err_q;

      // The register echoes newstatus one cycle late, so compare against
      // last cycle's word, starting once a full cycle has been written.
      always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
          exp_q <= '0;
          armed <= 1'b0;
          err_q <= 1'b0;
        end else begin
          exp_q <= bus.newstatus;
          armed <= 1'b1;
          if (armed && (bus.status != exp_q)) err_q <= 1'b1;
        end
      end

      assign bus.status_err = err_q;
    end else begin : g_nocheck
      assign bus.status_err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_psr_status_sequencer.sv
// Directed bench for psr_status_sequencer with a looped-back 1-cycle status register.
module tb_psr_status_sequencer;

  logic       clk;
  logic       preset;
  logic [4:0] reg_q;
  logic [4:0] corrupt;
  int         checks;
  int         errors;

  psr_status_sequencer_if #(.status_width(5)) bus ();

  psr_status_sequencer #(
    .status_width  (5),
    .TIMEOUT_CYCLES(4),
    .CHECK_EN      (1)
  ) dut (
    .clk   (clk),
    .preset(preset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) reg_q <= '0;
    else         reg_q <= bus.newstatus;
  end

  assign bus.status = reg_q ^ corrupt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    preset          = 1'b0;
    corrupt         = '0;
    bus.issue_valid = 1'b0;
    bus.issue_dual  = 1'b0;
    bus.done        = '0;
    bus.retire_ack  = 1'b0;

    step(); step();
    chk("rst_newstatus", 8'(bus.newstatus), 8'h00);
    chk("rst_ready", 8'(bus.issue_ready), 8'h01);
    chk("rst_start", 8'(bus.path_start), 8'h00);
    chk("rst_timeout", 8'(bus.timeout), 8'h00);
    chk("rst_err", 8'(bus.status_err), 8'h00);
    preset = 1'b1;
    step();

    // single path, done[0] in first WAIT cycle
    bus.issue_valid = 1'b1; bus.issue_dual = 1'b0;
    step();
    bus.issue_valid = 1'b0;
    chk("s_issue_ns", 8'(bus.newstatus), 8'h05);
    chk("s_issue_start", 8'(bus.path_start), 8'h01);
    chk("s_issue_ready", 8'(bus.issue_ready), 8'h00);
    step();
    chk("s_wait_ns", 8'(bus.newstatus), 8'h09);
    chk("s_wait_start", 8'(bus.path_start), 8'h00);
    bus.done = 2'b01;
    step();
    bus.done = '0;
    chk("s_retire_ns", 8'(bus.newstatus), 8'h1C);
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    chk("s_retire_hold", 8'(bus.newstatus), 8'h1C);
    bus.retire_ack = 1'b1;
    step();
    chk("s_idle_ns", 8'(bus.newstatus), 8'h00);
    chk("s_idle_ready", 8'(bus.issue_ready), 8'h01);
    step();
    bus.retire_ack = 1'b0;
    chk("ack_in_idle", 8'(bus.newstatus), 8'h00);

    // dual, done[1] at WAIT 1, done[0] at WAIT 4 (the timeout threshold)
    bus.issue_valid = 1'b1; bus.issue_dual = 1'b1;
    step();
    bus.issue_valid = 1'b0; bus.issue_dual = 1'b0;
    chk("d_issue_ns", 8'(bus.newstatus), 8'h07);
    chk("d_issue_start", 8'(bus.path_start), 8'h03);
    step();
    chk("d_wait1_ns", 8'(bus.newstatus), 8'h0B);
    bus.done = 2'b10;
    step();
    bus.done = '0;
    chk("d_wait2_ns", 8'(bus.newstatus), 8'h09);
    step();
    chk("d_wait3_ns", 8'(bus.newstatus), 8'h09);
    step();
    chk("d_wait4_ns", 8'(bus.newstatus), 8'h09);
    bus.done = 2'b01;
    step();
    bus.done = '0;
    chk("d_retire_ns", 8'(bus.newstatus), 8'h1C);
    chk("d_no_timeout", 8'(bus.timeout), 8'h00);
    bus.retire_ack = 1'b1;
    step();
    bus.retire_ack = 1'b0;

    // dual, both done together
    bus.issue_valid = 1'b1; bus.issue_dual = 1'b1;
    step();
    bus.issue_valid = 1'b0; bus.issue_dual = 1'b0;
    step();
    chk("b_wait_ns", 8'(bus.newstatus), 8'h0B);
    bus.done = 2'b11;
    step();
    bus.done = '0;
    chk("b_retire_ns", 8'(bus.newstatus), 8'h1C);
    bus.retire_ack = 1'b1;
    step();
    bus.retire_ack = 1'b0;

    // timeout after 4 WAIT cycles
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    step(); step(); step(); step();
    chk("t_wait4_ns", 8'(bus.newstatus), 8'h09);
    step();
    chk("t_retire_ns", 8'(bus.newstatus), 8'h1C);
    chk("t_timeout", 8'(bus.timeout), 8'h01);
    bus.retire_ack = 1'b1;
    step();
    bus.retire_ack = 1'b0;
    chk("t_timeout_idle", 8'(bus.timeout), 8'h01);
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    chk("t_timeout_clr", 8'(bus.timeout), 8'h00);

    // done during ISSUE still passes through one WAIT cycle
    bus.done = 2'b01;
    step();
    bus.done = '0;
    chk("i_wait_ns", 8'(bus.newstatus), 8'h08);
    step();
    chk("i_retire_ns", 8'(bus.newstatus), 8'h1C);
    bus.retire_ack = 1'b1;
    step();
    bus.retire_ack = 1'b0;
    chk("loop_err_clean", 8'(bus.status_err), 8'h00);

    // readback corruption
    corrupt = 5'b00100;
    step();
    corrupt = '0;
    chk("err_rise", 8'(bus.status_err), 8'h01);
    step(); step();
    chk("err_sticky", 8'(bus.status_err), 8'h01);

    // async reset during WAIT
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    step();
    chk("r_wait_ns", 8'(bus.newstatus), 8'h09);
    #2 preset = 1'b0;
    #1;
    chk("r_async_ns", 8'(bus.newstatus), 8'h00);
    chk("r_async_err", 8'(bus.status_err), 8'h00);
    step();
    preset = 1'b1;
    step();
    chk("r_after_ns", 8'(bus.newstatus), 8'h00);
    chk("r_after_start", 8'(bus.path_start), 8'h00);
    chk("r_after_ready", 8'(bus.issue_ready), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
